// File: rtl/tb_unified_mem_model.sv
// Unified RV32E bench memory: one word store behind a fetch port, an active-low SRAM data port and a backdoor loader.
// Optional fetch wait states are enabled by defining MEM_STALL_EN.
module tb_unified_mem_model #(
  parameter int          ADDR_W       = 16,
  parameter int          INST_LAT     = 1,
  parameter int          DATA_LAT     = 1,
  parameter logic [31:0] NOP_WORD     = 32'h00000013,
  parameter int          STALL_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       instruction,
  output logic              inst_ready,
  input  logic              sram_cen,
  input  logic              sram_wen,
  input  logic [3:0]        sram_ben,
  input  logic [31:0]       sram_addr,
  input  logic [31:0]       sram_din,
  output logic [31:0]       sram_dout,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_swap,
  output logic              oob_err
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] d_idx;
  logic [ADDR_W-1:0] i_idx;
  logic              d_oob;
  logic              i_oob;
  logic              ld_hit;
  logic              d_write;
  logic [31:0]       ld_word;
  logic              freeze;
  logic              unused_bits;

  logic [31:0]         d_pipe_reg [DATA_LAT];
  logic [31:0]         i_pipe_reg [INST_LAT];
  logic [INST_LAT-1:0] i_vld_reg;
  logic                oob_reg;

  assign d_idx       = sram_addr[ADDR_W+1:2];
  assign i_idx       = inst_addr[ADDR_W+1:2];
  assign d_oob       = |sram_addr[31:ADDR_W+2];
  assign i_oob       = |inst_addr[31:ADDR_W+2];
  assign unused_bits = ^{inst_addr[1:0], sram_addr[1:0]};

  assign ld_word = ld_swap ? {ld_data[7:0], ld_data[15:8], ld_data[23:16], ld_data[31:24]} : ld_data;
  // A backdoor write to the same word drops the whole data-port write, not just overlapping lanes.
  assign ld_hit  = ld_we && (ld_addr == d_idx);
  assign d_write = rst_n && !sram_cen && !sram_wen && !d_oob && !ld_hit;

  always_ff @(posedge clk) begin
    if (ld_we)
      mem[ld_addr] <= ld_word;
    if (d_write)
      for (int b = 0; b < 4; b++)
        if (!sram_ben[b])
          mem[d_idx][8*b +: 8] <= sram_din[8*b +: 8];
  end

  // Data read pipeline; reads see pre-write contents because the store updates non-blocking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_LAT; i++)
        d_pipe_reg[i] <= '0;
    end else begin
      d_pipe_reg[0] <= (sram_cen || d_oob) ? 32'h0 : mem[d_idx];
      for (int i = 1; i < DATA_LAT; i++)
        d_pipe_reg[i] <= d_pipe_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < INST_LAT; i++)
        i_pipe_reg[i] <= NOP_WORD;
      i_vld_reg <= '0;
    end else if (!freeze) begin
      i_pipe_reg[0] <= i_oob ? NOP_WORD : mem[i_idx];
      i_vld_reg[0]  <= 1'b1;
      for (int i = 1; i < INST_LAT; i++) begin
        i_pipe_reg[i] <= i_pipe_reg[i-1];
        i_vld_reg[i]  <= i_vld_reg[i-1];
      end
    end
  end

  // An out-of-range fetch flags even when a stall discards it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      oob_reg <= 1'b0;
    else if (i_oob || (!sram_cen && d_oob))
      oob_reg <= 1'b1;
  end

`ifdef MEM_STALL_EN
  logic [7:0]        stall_cnt_reg;
  logic [7:0]        stall_cnt_next;
  logic [INST_LAT:0] vld_ext;
  logic              fill_next;
  logic              ready_reg;

  // vld_ext[INST_LAT-1] is what the last valid stage would hold after this edge.
  assign vld_ext   = {i_vld_reg, 1'b1};
  assign fill_next = vld_ext[INST_LAT-1];

  always_comb begin
    stall_cnt_next = 8'd0;
    if (i_vld_reg[INST_LAT-1])
      stall_cnt_next = (stall_cnt_reg == 8'(STALL_PERIOD - 1)) ? 8'd0 : stall_cnt_reg + 8'd1;
  end

  assign freeze = fill_next && (stall_cnt_next == 8'(STALL_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= 8'd0;
      ready_reg     <= 1'b0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      ready_reg     <= fill_next && !freeze;
    end
  end

  assign inst_ready = ready_reg;
`else
  assign freeze     = 1'b0;
  assign inst_ready = i_vld_reg[INST_LAT-1];
`endif

  assign instruction = i_pipe_reg[INST_LAT-1];
  assign sram_dout   = d_pipe_reg[DATA_LAT-1];
  assign oob_err     = oob_reg;

endmodule

// File: tb/tb_tb_unified_mem_model.sv
// Directed bench for the unified memory model; a per-cycle reference model predicts every output.
module tb_tb_unified_mem_model;
  localparam int          AW  = 16;
  localparam int          IL  = 1;
  localparam int          DL  = 3;
  localparam int          SP  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   inst_addr;
  logic [31:0]   instruction;
  logic          inst_ready;
  logic          sram_cen;
  logic          sram_wen;
  logic [3:0]    sram_ben;
  logic [31:0]   sram_addr;
  logic [31:0]   sram_din;
  logic [31:0]   sram_dout;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_swap;
  logic          oob_err;

  always #5 clk = ~clk;

  tb_unified_mem_model #(
    .ADDR_W(AW), .INST_LAT(IL), .DATA_LAT(DL), .NOP_WORD(NOP), .STALL_PERIOD(SP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .instruction(instruction),
    .inst_ready(inst_ready), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_swap(ld_swap), .oob_err(oob_err)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if ($isunknown(exp)) return;
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_inst(input string name, input logic [31:0] exp);
`ifndef MEM_STALL_EN
    check(name, instruction, exp);
`endif
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference model: word store plus the value each posedge pushes toward each output.
  logic [31:0] mdl_mem [int];
  logic [31:0] push_i  [int];
  logic [31:0] push_d  [int];
  logic        mdl_oob  = 1'b0;
  logic        started  = 1'b0;
  int          cyc      = 0;
  int          last_rst = -1000;

  function automatic logic [31:0] rd_mem(input int i);
    return mdl_mem.exists(i) ? mdl_mem[i] : 32'hx;
  endfunction

  always @(posedge clk) begin : model
    int n, di, fi;
    logic dob, iob;
    logic [31:0] w;
    n   = cyc;
    di  = int'(sram_addr[AW+1:2]);
    fi  = int'(inst_addr[AW+1:2]);
    dob = |sram_addr[31:AW+2];
    iob = |inst_addr[31:AW+2];
    if (!rst_n) begin
      started   = 1'b1;
      last_rst  = n;
      mdl_oob   = 1'b0;
      push_i[n] = NOP;
      push_d[n] = 32'h0;
    end else begin
      push_i[n] = iob ? NOP : rd_mem(fi);
      push_d[n] = (sram_cen || dob) ? 32'h0 : rd_mem(di);
      if (iob || (!sram_cen && dob)) mdl_oob = 1'b1;
    end
    if (ld_we)
      mdl_mem[int'(ld_addr)] = ld_swap ? {ld_data[7:0], ld_data[15:8], ld_data[23:16], ld_data[31:24]} : ld_data;
    if (rst_n && !sram_cen && !sram_wen && !dob && !(ld_we && int'(ld_addr) == di)) begin
      w = rd_mem(di);
      for (int b = 0; b < 4; b++)
        if (!sram_ben[b]) w[8*b +: 8] = sram_din[8*b +: 8];
      mdl_mem[di] = w;
    end
    cyc = n + 1;
  end

  logic [31:0] prev_inst = NOP;

  always @(posedge clk) begin : compare
    int m;
    logic er;
    logic [31:0] ed;
    #1;
    if (started) begin
      m  = cyc - 1;
      ed = (m - last_rst >= DL) ? push_d[m-DL+1] : 32'h0;
`ifdef MEM_STALL_EN
      er = (m - last_rst >= IL) && (((m - last_rst - IL) % SP) != SP - 1);
      check("cyc_ready", 32'(inst_ready), 32'(er));
      if (m - last_rst < IL)
        check("cyc_inst_reset", instruction, NOP);
      else if (!er)
        check("cyc_inst_hold", instruction, prev_inst);
`else
      er = (m - last_rst >= IL);
      check("cyc_ready", 32'(inst_ready), 32'(er));
      check("cyc_inst", instruction, er ? push_i[m-IL+1] : NOP);
`endif
      check("cyc_dout", sram_dout, ed);
      check("cyc_oob", 32'(oob_err), 32'(mdl_oob));
      prev_inst = instruction;
    end
  end

  initial begin
    rst_n = 1'b0; inst_addr = '0; sram_cen = 1'b1; sram_wen = 1'b1; sram_ben = 4'hF;
    sram_addr = '0; sram_din = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_swap = 1'b0;

    // Preload words 0..15 with 0x1000_000i while reset is held.
    for (int i = 0; i < 16; i++) begin
      ld_we = 1'b1; ld_addr = AW'(i); ld_data = 32'h10000000 + 32'(i);
      step();
    end
    ld_we = 1'b0;
    $display("txn reset: inst=%h ready=%b dout=%h oob=%b", instruction, inst_ready, sram_dout, oob_err);
    check("rst_inst", instruction, NOP);
    check("rst_ready", 32'(inst_ready), 32'd0);
    check("rst_dout", sram_dout, 32'h0);
    check("rst_oob", 32'(oob_err), 32'd0);

    rst_n = 1'b1;
    step();
    $display("txn release: ready=%b inst=%h", inst_ready, instruction);
    check("release_ready", 32'(inst_ready), 32'd1);
    check_inst("release_inst", 32'h10000000);

    // Swapped backdoor write to word 1 while fetching it: old value first, swapped value next.
    ld_we = 1'b1; ld_addr = AW'(1); ld_data = 32'h93001000; ld_swap = 1'b1; inst_addr = 32'h4;
    step();
    ld_we = 1'b0; ld_swap = 1'b0;
    check_inst("fetch_bd_collide", 32'h10000001);
    step();
    $display("txn swap fetch: inst=%h", instruction);
    check_inst("swap_fetch", 32'h00100093);
    inst_addr = 32'h0;

    // Byte-enable merge on word 2.
    sram_cen = 1'b0; sram_wen = 1'b0; sram_addr = 32'h8; sram_din = 32'hAABBCCDD; sram_ben = 4'b0000;
    step();
    sram_din = 32'h11223344; sram_ben = 4'b1010;
    step();
    sram_wen = 1'b1; sram_ben = 4'hF;
    step();
    sram_cen = 1'b1;
    step();
    step();
    $display("txn be read: dout=%h", sram_dout);
    check("be_read", sram_dout, 32'hAA22CC44);
    step();
    check("be_idle", sram_dout, 32'h0);

    // Read-before-write on word 12.
    sram_cen = 1'b0; sram_wen = 1'b0; sram_ben = 4'h0; sram_addr = 32'h30; sram_din = 32'd5;
    step();
    sram_din = 32'd7;
    step();
    sram_wen = 1'b1;
    step();
    sram_cen = 1'b1;
    step();
    check("rbw_old", sram_dout, 32'd5);
    step();
    $display("txn rbw: dout=%h", sram_dout);
    check("rbw_new", sram_dout, 32'd7);

    // Backdoor against a data read (word 6) and a data write (word 7).
    sram_cen = 1'b0; sram_wen = 1'b1; sram_addr = 32'h18;
    ld_we = 1'b1; ld_addr = AW'(6); ld_data = 32'hDEADBEEF;
    step();
    sram_wen = 1'b0; sram_ben = 4'h0; sram_addr = 32'h1C; sram_din = 32'h55555555;
    ld_addr = AW'(7); ld_data = 32'hCAFEF00D;
    step();
    ld_we = 1'b0; sram_wen = 1'b1; sram_ben = 4'hF; sram_addr = 32'h18;
    step();
    check("bd_read_old", sram_dout, 32'h10000006);
    sram_addr = 32'h1C;
    step();
    sram_cen = 1'b1;
    step();
    check("bd_read_new", sram_dout, 32'hDEADBEEF);
    step();
    $display("txn bd wins: dout=%h", sram_dout);
    check("bd_wins", sram_dout, 32'hCAFEF00D);

    // Fetch of word 4 in the same cycle as a data write to it.
    inst_addr = 32'h10; sram_cen = 1'b0; sram_wen = 1'b0; sram_ben = 4'h0;
    sram_addr = 32'h10; sram_din = 32'h0BADF00D;
    step();
    sram_cen = 1'b1; sram_wen = 1'b1; sram_ben = 4'hF;
    check_inst("fetch_wr_old", 32'h10000004);
    step();
    check_inst("fetch_wr_new", 32'h0BADF00D);
    inst_addr = 32'h0;

    // Out-of-range data write, then legal traffic, then out-of-range fetch.
    check("oob_clear", 32'(oob_err), 32'd0);
    sram_cen = 1'b0; sram_wen = 1'b0; sram_ben = 4'h0; sram_addr = 32'h0004_0000; sram_din = 32'hFFFFFFFF;
    step();
    check("oob_set", 32'(oob_err), 32'd1);
    sram_wen = 1'b1; sram_ben = 4'hF; sram_addr = 32'h0;
    step();
    sram_cen = 1'b1;
    step();
    check("oob_dout", sram_dout, 32'h0);
    step();
    $display("txn oob: dout=%h oob=%b", sram_dout, oob_err);
    check("oob_nowrite", sram_dout, 32'h10000000);
    check("oob_sticky", 32'(oob_err), 32'd1);
    inst_addr = 32'h0004_0000;
    step();
    check_inst("oob_fetch", NOP);
    inst_addr = 32'h0;

    // Reset mid-operation with a pending read and a write presented in the reset cycle.
    sram_cen = 1'b0; sram_wen = 1'b1; sram_addr = 32'h1C;
    step();
    rst_n = 1'b0; sram_wen = 1'b0; sram_ben = 4'h0; sram_addr = 32'h14; sram_din = 32'h0;
    step();
    $display("txn mid reset: dout=%h oob=%b ready=%b", sram_dout, oob_err, inst_ready);
    check("mrst_dout", sram_dout, 32'h0);
    check("mrst_oob", 32'(oob_err), 32'd0);
    check("mrst_ready", 32'(inst_ready), 32'd0);
    check_inst("mrst_inst", NOP);
    rst_n = 1'b1; sram_wen = 1'b1; sram_ben = 4'hF;
    step();
    sram_cen = 1'b1;
    step();
    step();
    check("mrst_nowrite", sram_dout, 32'h10000005);

`ifdef MEM_STALL_EN
    for (int i = 0; i < 12; i++) begin
      inst_addr = 32'(4 * i);
      step();
      $display("txn stall fetch %0d: ready=%b inst=%h", i, inst_ready, instruction);
    end
    inst_addr = 32'h0;
`endif

    step();
    step();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
